// File: rtl/prover_ctrl_pkg.sv
// rtl/prover_ctrl_pkg.sv - shared field constants, lane count, state enum and field add for the compute_v controller
package prover_ctrl_pkg;

   // Field modulus 2^61-1; all lane values are kept strictly below F_Q.
   localparam int F_NBITS = 61;
   localparam logic [F_NBITS-1:0] F_Q = 61'h1FFF_FFFF_FFFF_FFFF;

   localparam int NLANES = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_EMIT  = 2'd3
   } ctrl_state_t;

   // Modular add of two reduced operands: one conditional subtract is enough.
   function automatic logic [F_NBITS-1:0] f_add(input logic [F_NBITS-1:0] a,
                                                input logic [F_NBITS-1:0] b);
      logic [F_NBITS:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
      return s[F_NBITS-1:0];
   endfunction

endpackage

// File: rtl/prover_ctrl_lane_acc.sv
// rtl/prover_ctrl_lane_acc.sv - one accumulator lane: register plus mod-F_Q adder with clear/add enables
module prover_ctrl_lane_acc
   import prover_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rstb,
   input  logic               clr,
   input  logic               add,
   input  logic [F_NBITS-1:0] b,
   output logic [F_NBITS-1:0] acc
);

   // Clear has priority so a round boundary never folds a stray value in.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)     acc <= '0;
      else if (clr)  acc <= '0;
      else if (add)  acc <= f_add(acc, b);
   end

endmodule

// File: rtl/prover_compute_v_early_ctrl.sv
// rtl/prover_compute_v_early_ctrl.sv - round/copy sequencer for one early-gates compute_v layer (optional watchdog: PROVER_CTRL_TIMEOUT_EN)
module prover_compute_v_early_ctrl
   import prover_ctrl_pkg::*;
#(
   parameter int maxcopies  = 8,
   parameter int maxrounds  = 16,
   parameter int ncbits     = $clog2(maxcopies + 1),
   parameter int nrbits     = $clog2(maxrounds + 1),
   parameter int tmo_cycles = 1024
) (
   input  logic                            clk,
   input  logic                            rstb,
   input  logic                            start,
   input  logic [ncbits-1:0]               ncopies,
   input  logic [nrbits-1:0]               nrounds,
   output logic                            lay_en,
   output logic                            lay_mask_en,
   input  logic                            lay_in_ready,
   input  logic                            lay_out_pulse,
   input  logic [NLANES-1:0][F_NBITS-1:0]  lay_v_out,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic [NLANES-1:0][F_NBITS-1:0]  res,
   output logic [nrbits-1:0]               res_round,
   output logic                            busy,
   output logic                            done_pulse,
   output logic                            err
);

   // Derived widths are not meant to be overridden; stop elaboration if they are.
   if (ncbits != $clog2(maxcopies + 1) || nrbits != $clog2(maxrounds + 1) || tmo_cycles < 1) begin : g_bad_param
      $error("prover_compute_v_early_ctrl: ncbits/nrbits must not be overridden, tmo_cycles must be >= 1");
   end

   ctrl_state_t        state_q, state_d;
   logic [ncbits-1:0]  copy_q, ncopies_q;
   logic [nrbits-1:0]  round_q, nrounds_q;
   logic               done_q;
   logic               load, acc_clr, acc_add, hs;
   logic               copy_last, round_last;

   assign copy_last  = (copy_q == ncopies_q - ncbits'(1));
   assign round_last = (round_q == nrounds_q - nrbits'(1));

`ifdef PROVER_CTRL_TIMEOUT_EN
   localparam int TMO_W = $clog2(tmo_cycles + 1);
   logic [TMO_W-1:0] tmo_q;
   logic             tmo_hit;
   logic             err_q;
`endif

   // State register.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state and one-cycle strobes; en only leaves ST_ISSUE, so at most one en per out pulse.
   always_comb begin
      state_d     = state_q;
      lay_en      = 1'b0;
      lay_mask_en = 1'b0;
      load        = 1'b0;
      acc_clr     = 1'b0;
      acc_add     = 1'b0;
      hs          = 1'b0;
`ifdef PROVER_CTRL_TIMEOUT_EN
      tmo_hit     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start && ncopies != '0 && nrounds != '0) begin
               load    = 1'b1;
               acc_clr = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (lay_in_ready) begin
               lay_en      = 1'b1;
               lay_mask_en = (copy_q == '0);
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lay_out_pulse) begin
               acc_add = 1'b1;
               state_d = copy_last ? ST_EMIT : ST_ISSUE;
            end
`ifdef PROVER_CTRL_TIMEOUT_EN
            else if (tmo_q == TMO_W'(tmo_cycles - 1)) begin
               tmo_hit = 1'b1;
               acc_clr = 1'b1;
               state_d = ST_IDLE;
            end
`endif
         end
         ST_EMIT: begin
            if (res_ready) begin
               hs      = 1'b1;
               acc_clr = 1'b1;
               state_d = round_last ? ST_IDLE : ST_ISSUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Run parameters, copy/round counters and the post-run done strobe.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ncopies_q <= '0;
         nrounds_q <= '0;
         copy_q    <= '0;
         round_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         if (load) begin
            ncopies_q <= ncopies;
            nrounds_q <= nrounds;
            copy_q    <= '0;
            round_q   <= '0;
         end
         if (acc_add) copy_q <= copy_q + ncbits'(1);
         if (hs) begin
            copy_q <= '0;
            if (!round_last) round_q <= round_q + nrbits'(1);
         end
         done_q <= hs && round_last;
      end
   end

`ifdef PROVER_CTRL_TIMEOUT_EN
   // Watchdog: restarts on each en, counts only while waiting for the layer; err is sticky.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (lay_en)                 tmo_q <= '0;
         else if (state_q == ST_WAIT) tmo_q <= tmo_q + TMO_W'(1);
         if (tmo_hit) err_q <= 1'b1;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      prover_ctrl_lane_acc u_lane (
         .clk  (clk),
         .rstb (rstb),
         .clr  (acc_clr),
         .add  (acc_add),
         .b    (lay_v_out[i]),
         .acc  (res[i])
      );
   end

   assign res_valid  = (state_q == ST_EMIT);
   assign res_round  = round_q;
   assign busy       = (state_q != ST_IDLE);
   assign done_pulse = done_q;

endmodule

// File: tb/tb_prover_compute_v_early_ctrl.sv
// tb/tb_prover_compute_v_early_ctrl.sv - randomized self-checking bench with a round-sum reference model
module tb_prover_compute_v_early_ctrl;
   import prover_ctrl_pkg::*;

   localparam int NCB = 4;
   localparam int NRB = 5;
   localparam int TMO = 16;

   logic                            clk = 1'b0;
   logic                            rstb = 1'b0;
   logic                            start = 1'b0;
   logic [NCB-1:0]                  ncopies = '0;
   logic [NRB-1:0]                  nrounds = '0;
   logic                            lay_en, lay_mask_en;
   logic                            lay_in_ready = 1'b0;
   logic                            lay_out_pulse = 1'b0;
   logic [NLANES-1:0][F_NBITS-1:0]  lay_v_out = '0;
   logic                            res_valid;
   logic                            res_ready = 1'b0;
   logic [NLANES-1:0][F_NBITS-1:0]  res;
   logic [NRB-1:0]                  res_round;
   logic                            busy, done_pulse, err;

   int vectors = 0;
   int miscompares = 0;
   longint unsigned fq;

   always #5 clk = ~clk;

   prover_compute_v_early_ctrl #(.maxcopies(8), .maxrounds(16), .tmo_cycles(TMO)) dut (
      .clk(clk), .rstb(rstb), .start(start), .ncopies(ncopies), .nrounds(nrounds),
      .lay_en(lay_en), .lay_mask_en(lay_mask_en), .lay_in_ready(lay_in_ready),
      .lay_out_pulse(lay_out_pulse), .lay_v_out(lay_v_out),
      .res_valid(res_valid), .res_ready(res_ready), .res(res), .res_round(res_round),
      .busy(busy), .done_pulse(done_pulse), .err(err)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint unsigned rand_fe();
      longint unsigned x;
      x = {$urandom, $urandom};
      return x % fq;
   endfunction

   task automatic check_res(input longint unsigned exp[NLANES]);
      for (int i = 0; i < NLANES; i++) check_val("res_lane", 64'(res[i]), exp[i]);
   endtask

   task automatic apply_start(input int nc, input int nr);
      ncopies = NCB'(nc);
      nrounds = NRB'(nr);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // mode 0: random lanes; 1: lanes {4,3,2,1}; 2: lane0 = F_Q-1, others random.
   task automatic run(input int nc, input int nr, input int mode, input int issue_stall, input int hold_force);
      longint unsigned exp[NLANES];
      int stall, dly, hold;
      apply_start(nc, nr);
      #1 check_val("busy_after_start", 64'(busy), 64'd1);
      for (int r = 0; r < nr; r++) begin
         for (int i = 0; i < NLANES; i++) exp[i] = 0;
         for (int c = 0; c < nc; c++) begin
            stall = (issue_stall >= 0) ? issue_stall : $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
               lay_in_ready = 1'b0;
               #1 check_val("no_en_when_not_ready", 64'(lay_en), 64'd0);
               @(negedge clk);
            end
            lay_in_ready = 1'b1;
            #1 check_val("en_issue", 64'(lay_en), 64'd1);
            check_val("mask_en", 64'(lay_mask_en), 64'(c == 0));
            @(negedge clk);
            dly = $urandom_range(0, 3);
            for (int k = 0; k < dly; k++) begin
               lay_in_ready = 1'($urandom);
               start = 1'($urandom);
               ncopies = NCB'($urandom_range(1, 8));
               lay_v_out[0] = F_NBITS'(rand_fe());
               #1 check_val("no_en_in_wait", 64'(lay_en), 64'd0);
               @(negedge clk);
            end
            start = 1'b0;
            for (int i = 0; i < NLANES; i++) begin
               longint unsigned v;
               if (mode == 1)                v = longint'(i + 1);
               else if (mode == 2 && i == 0) v = fq - 1;
               else                          v = rand_fe();
               lay_v_out[i] = F_NBITS'(v);
               exp[i] = (exp[i] + v) % fq;
            end
            lay_out_pulse = 1'b1;
            @(negedge clk);
            lay_out_pulse = 1'b0;
            for (int i = 0; i < NLANES; i++) lay_v_out[i] = F_NBITS'(rand_fe());
         end
         #1 check_val("res_valid", 64'(res_valid), 64'd1);
         check_val("res_round", 64'(res_round), 64'(r));
         check_res(exp);
         hold = (hold_force >= 0) ? hold_force : $urandom_range(0, 3);
         for (int k = 0; k < hold; k++) begin
            res_ready = 1'b0;
            lay_in_ready = 1'b1;
            lay_out_pulse = 1'($urandom);
            @(negedge clk);
            lay_out_pulse = 1'b0;
            #1 check_val("res_valid_hold", 64'(res_valid), 64'd1);
            check_val("no_en_in_emit", 64'(lay_en), 64'd0);
            check_res(exp);
         end
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
         #1 check_val("done_pulse", 64'(done_pulse), 64'(r == nr - 1));
         check_val("busy_after_accept", 64'(busy), 64'(r != nr - 1));
      end
      @(negedge clk);
      check_val("done_pulse_one_cycle", 64'(done_pulse), 64'd0);
      check_val("err_clear", 64'(err), 64'd0);
   endtask

   initial begin
      longint unsigned zero4[NLANES];
      fq = 64'(F_Q);
      for (int i = 0; i < NLANES; i++) zero4[i] = 0;

      // Reset values
      #1;
      check_val("rst_lay_en", 64'(lay_en), 64'd0);
      check_val("rst_mask_en", 64'(lay_mask_en), 64'd0);
      check_val("rst_res_valid", 64'(res_valid), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done_pulse), 64'd0);
      check_val("rst_err", 64'(err), 64'd0);
      check_val("rst_round", 64'(res_round), 64'd0);
      check_res(zero4);
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);

      run(1, 1, 1, 0, 0);          // single copy, single round, lanes {4,3,2,1}
      run(3, 1, 2, -1, -1);        // lane0 wraps twice
      run(2, 2, 0, -1, 5);         // consumer stalls 5 cycles
      run(1, 1, 0, 10, -1);        // layer not ready for 10 cycles

      // Zero-size starts are ignored
      apply_start(0, 2);
      #1 check_val("ignore_nc0", 64'(busy), 64'd0);
      @(negedge clk);
      apply_start(2, 0);
      #1 check_val("ignore_nr0", 64'(busy), 64'd0);
      @(negedge clk);
      // Stray out pulse while idle
      lay_v_out[0] = F_NBITS'(64'd77);
      lay_out_pulse = 1'b1;
      @(negedge clk);
      lay_out_pulse = 1'b0;
      #1 check_res(zero4);
      check_val("stray_busy", 64'(busy), 64'd0);
      @(negedge clk);

      for (int t = 0; t < 20; t++)
         run($urandom_range(1, 8), $urandom_range(1, 4), 0, -1, -1);
      run(8, 16, 0, 0, 0);         // maximum sizes

`ifdef PROVER_CTRL_TIMEOUT_EN
      apply_start(1, 1);
      lay_in_ready = 1'b1;
      @(negedge clk);              // en issued, now in WAIT
      lay_in_ready = 1'b0;
      repeat (TMO - 1) @(negedge clk);
      #1 check_val("tmo_not_yet", 64'(err), 64'd0);
      check_val("tmo_busy_before", 64'(busy), 64'd1);
      @(negedge clk);
      #1 check_val("tmo_err", 64'(err), 64'd1);
      check_val("tmo_busy_after", 64'(busy), 64'd0);
      check_val("tmo_no_valid", 64'(res_valid), 64'd0);
      @(negedge clk);
`endif

      // Reset in the middle of a run with a non-zero accumulator
      apply_start(2, 1);
      lay_in_ready = 1'b1;
      @(negedge clk);
      lay_v_out[0] = F_NBITS'(64'd5);
      lay_out_pulse = 1'b1;
      @(negedge clk);
      lay_out_pulse = 1'b0;
      #1 rstb = 1'b0;
      #1 check_val("midrst_busy", 64'(busy), 64'd0);
      check_val("midrst_en", 64'(lay_en), 64'd0);
      check_val("midrst_err", 64'(err), 64'd0);
      check_val("midrst_valid", 64'(res_valid), 64'd0);
      check_res(zero4);
      @(negedge clk);
      rstb = 1'b1;
      lay_in_ready = 1'b0;
      @(negedge clk);
      run(2, 2, 0, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
